grid_ctl: RTL and testbench



---
 rtl/grid_pkg.sv | 32 +++
 rtl/grid_ram.sv | 37 +++
 rtl/grid_ctl.sv | 188 ++++++++++++++++++
 tb/tb_grid_ctl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared cell/command/result types and address helper for the ship grid
package grid_pkg;

  localparam int DEF_GRID_SIZE = 12;
  localparam int DEF_MAX_LEN   = 5;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SHIP  = 2'd1,
    CELL_HIT   = 2'd2,
    CELL_MISS  = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_PLACE = 2'd1,
    OP_SHOOT = 2'd2,
    OP_RSVD  = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    RES_OK     = 2'd0,
    RES_REJECT = 2'd1,
    RES_HIT    = 2'd2,
    RES_MISS   = 2'd3
  } result_t;

  function automatic logic [7:0] pack_addr(input logic [3:0] x, input logic [3:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/grid_ram.sv
// rtl/grid_ram.sv - 256x2 grid memory, one read/write port plus one read-only display port
// Both read ports are registered and read-first; contents are never reset.
module grid_ram (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       a_we_i,
  input  logic [7:0] a_addr_i,
  input  logic [1:0] a_wdata_i,
  output logic [1:0] a_rdata_o,
  input  logic [7:0] b_addr_i,
  output logic [1:0] b_rdata_o
);

  logic [1:0] mem_q [256];
  logic [1:0] a_rdata_q;
  logic [1:0] b_rdata_q;

  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_rdata_q <= 2'd0;
      b_rdata_q <= 2'd0;
    end else begin
      a_rdata_q <= mem_q[a_addr_i];
      b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/grid_ctl.sv
// rtl/grid_ctl.sv - command sequencer (clear/place/shoot) and display read port for one ship grid
module grid_ctl
  import grid_pkg::*;
#(
  parameter int GRID_SIZE = DEF_GRID_SIZE,
  parameter int MAX_LEN   = DEF_MAX_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_x,
  input  logic [3:0] cmd_y,
  input  logic [2:0] cmd_len,
  input  logic       cmd_dir,
  output logic       done,
  output logic [1:0] result,
  input  logic [7:0] disp_addr,
  output logic [1:0] disp_status
);

  typedef enum logic [2:0] {
    ST_CLEAR, ST_IDLE, ST_CHECK, ST_WRITE, ST_SHOT_RD, ST_SHOT_WR, ST_DONE
  } state_t;

  localparam logic [4:0] GRID5   = 5'(GRID_SIZE);
  localparam logic [2:0] MAXLEN3 = 3'(MAX_LEN);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       clr_cmd_q, clr_cmd_d;
  logic [3:0] x_q, x_d, y_q, y_d;
  logic [2:0] len_q, len_d;
  logic       dir_q, dir_d;
  result_t    result_q, result_d;

  logic       ram_we;
  logic [7:0] ram_addr;
  cell_t      ram_wdata;
  logic [1:0] ram_rdata;
  cell_t      rd_cell;
  logic [3:0] cell_x, cell_y;
  logic [4:0] place_end;
  logic       place_bad, shot_bad;

  // cnt_q doubles as the sweep address in CLEAR and the ship cell index in CHECK/WRITE
  assign cell_x  = x_q + (dir_q ? 4'd0 : cnt_q[3:0]);
  assign cell_y  = y_q + (dir_q ? cnt_q[3:0] : 4'd0);
  assign rd_cell = cell_t'(ram_rdata);

  // 5-bit end coordinate so an origin near 15 plus length cannot wrap back into range
  assign place_end = (cmd_dir ? {1'b0, cmd_y} : {1'b0, cmd_x}) + {2'b00, cmd_len} - 5'd1;
  assign place_bad = (cmd_len == 3'd0) || (cmd_len > MAXLEN3) ||
                     ({1'b0, cmd_x} >= GRID5) || ({1'b0, cmd_y} >= GRID5) ||
                     (place_end >= GRID5);
  assign shot_bad  = ({1'b0, cmd_x} >= GRID5) || ({1'b0, cmd_y} >= GRID5);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_cmd_d = clr_cmd_q;
    x_d       = x_q;
    y_d       = y_q;
    len_d     = len_q;
    dir_d     = dir_q;
    result_d  = result_q;
    ram_we    = 1'b0;
    ram_wdata = CELL_EMPTY;
    ram_addr  = pack_addr(cell_x, cell_y);

    case (state_q)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        cnt_d    = cnt_q + 8'd1;
        if (cnt_q == 8'd255) begin
          if (clr_cmd_q) begin
            state_d  = ST_DONE;
            result_d = RES_OK;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          x_d       = cmd_x;
          y_d       = cmd_y;
          len_d     = cmd_len;
          dir_d     = cmd_dir;
          cnt_d     = 8'd0;
          clr_cmd_d = 1'b0;
          state_d   = ST_DONE;
          result_d  = RES_REJECT;
          case (cmd_op_t'(cmd_op))
            OP_CLEAR: begin
              clr_cmd_d = 1'b1;
              state_d   = ST_CLEAR;
            end
            OP_PLACE: if (!place_bad) state_d = ST_CHECK;
            OP_SHOOT: if (!shot_bad) state_d = ST_SHOT_RD;
            default: ;
          endcase
        end
      end
      ST_CHECK: begin
        // read of cell cnt_q is issued now; the data compared is for cell cnt_q-1
        if (cnt_q != 8'd0 && rd_cell != CELL_EMPTY) begin
          state_d  = ST_DONE;
          result_d = RES_REJECT;
        end else if (cnt_q[2:0] == len_q) begin
          state_d = ST_WRITE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WRITE: begin
        ram_we    = 1'b1;
        ram_wdata = CELL_SHIP;
        if (cnt_q[2:0] == len_q - 3'd1) begin
          state_d  = ST_DONE;
          result_d = RES_OK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SHOT_RD: state_d = ST_SHOT_WR;
      ST_SHOT_WR: begin
        state_d = ST_DONE;
        case (rd_cell)
          CELL_EMPTY: begin
            ram_we    = 1'b1;
            ram_wdata = CELL_MISS;
            result_d  = RES_MISS;
          end
          CELL_SHIP: begin
            ram_we    = 1'b1;
            ram_wdata = CELL_HIT;
            result_d  = RES_HIT;
          end
          default: result_d = RES_REJECT;
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= 8'd0;
      clr_cmd_q <= 1'b0;
      x_q       <= 4'd0;
      y_q       <= 4'd0;
      len_q     <= 3'd0;
      dir_q     <= 1'b0;
      result_q  <= RES_OK;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_cmd_q <= clr_cmd_d;
      x_q       <= x_d;
      y_q       <= y_d;
      len_q     <= len_d;
      dir_q     <= dir_d;
      result_q  <= result_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;

  grid_ram u_ram (
    .clk_i     (clk),
    .rst_i     (rst),
    .a_we_i    (ram_we),
    .a_addr_i  (ram_addr),
    .a_wdata_i (ram_wdata),
    .a_rdata_o (ram_rdata),
    .b_addr_i  (disp_addr),
    .b_rdata_o (disp_status)
  );

endmodule

// File: tb/tb_grid_ctl.sv
// tb/tb_grid_ctl.sv - self-checking bench for grid_ctl against a cell-array reference model
module tb_grid_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_x = 4'd0;
  logic [3:0] cmd_y = 4'd0;
  logic [2:0] cmd_len = 3'd0;
  logic       cmd_dir = 1'b0;
  logic       done;
  logic [1:0] result;
  logic [7:0] disp_addr = 8'd0;
  logic [1:0] disp_status;

  int total = 0;
  int bad = 0;
  int model [256];

  grid_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_len     (cmd_len),
    .cmd_dir     (cmd_dir),
    .done        (done),
    .result      (result),
    .disp_addr   (disp_addr),
    .disp_status (disp_status)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_empty();
    for (int i = 0; i < 256; i++) model[i] = 0;
  endtask

  // Reference: result code and done cycle straight from the command rules.
  // Cell codes: 0 empty, 1 ship, 2 hit, 3 miss. Results: 0 ok, 1 reject, 2 hit, 3 miss.
  task automatic model_cmd(input int op, input int x, input int y, input int len, input int dir,
                           output int res, output int cyc);
    int k;
    res = 1;
    cyc = 1;
    if (op == 0) begin
      model_empty();
      res = 0;
      cyc = 257;
    end else if (op == 1) begin
      if (len >= 1 && len <= 5 && x <= 11 && y <= 11 && ((dir != 0) ? y : x) + len - 1 <= 11) begin
        k = -1;
        for (int i = 0; i < len; i++) begin
          if (k < 0 && model[(x + (dir != 0 ? 0 : i)) * 16 + y + (dir != 0 ? i : 0)] != 0) k = i;
        end
        if (k >= 0) begin
          cyc = k + 3;
        end else begin
          for (int i = 0; i < len; i++) model[(x + (dir != 0 ? 0 : i)) * 16 + y + (dir != 0 ? i : 0)] = 1;
          res = 0;
          cyc = 2 * len + 2;
        end
      end
    end else if (op == 2) begin
      if (x <= 11 && y <= 11) begin
        cyc = 3;
        if (model[x * 16 + y] == 0) begin
          model[x * 16 + y] = 3;
          res = 3;
        end else if (model[x * 16 + y] == 1) begin
          model[x * 16 + y] = 2;
          res = 2;
        end
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    ok = (cmd_ready === 1'b1);
  endtask

  task automatic drive_cmd(input int op, input int x, input int y, input int len, input int dir);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_x     = 4'(x);
    cmd_y     = 4'(y);
    cmd_len   = 3'(len);
    cmd_dir   = 1'(dir);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_x     = 4'($urandom);
    cmd_y     = 4'($urandom);
    cmd_len   = 3'($urandom);
    cmd_dir   = 1'($urandom);
  endtask

  task automatic issue(input int op, input int x, input int y, input int len, input int dir,
                       output int res, output int cyc);
    bit ok;
    res = -1;
    cyc = -1;
    wait_ready(ok);
    if (ok) begin
      drive_cmd(op, x, y, len, dir);
      for (int c = 1; c <= 400; c++) begin
        @(negedge clk);
        if (done === 1'b1) begin
          res = int'(result);
          cyc = c;
          break;
        end
      end
    end
  endtask

  task automatic run_cmd(input string tag, input int op, input int x, input int y,
                         input int len, input int dir);
    int er, ec, gr, gc;
    model_cmd(op, x, y, len, dir, er, ec);
    issue(op, x, y, len, dir, gr, gc);
    chk({tag, "_result"}, gr, er);
    chk({tag, "_cycle"}, gc, ec);
  endtask

  task automatic sweep(input string tag);
    for (int x = 0; x < 12; x++) begin
      for (int y = 0; y < 12; y++) begin
        @(negedge clk);
        disp_addr = 8'(x * 16 + y);
        @(negedge clk);
        chk($sformatf("%s_cell_%0d_%0d", tag, x, y), 32'(disp_status), model[x * 16 + y]);
      end
    end
  endtask

  // Called just after rst is dropped: the next falling edge lies in cycle 1.
  task automatic boot_check(input string tag);
    int first, done_seen;
    first = -1;
    done_seen = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (cmd_ready === 1'b1) begin
        first = n;
        break;
      end
    end
    chk({tag, "_ready_cycle"}, first, 257);
    chk({tag, "_no_done"}, done_seen, 0);
  endtask

  initial begin
    int old [256];
    int early, done_seen, op, r;
    bit ok;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_disp_status", 32'(disp_status), 0);

    @(posedge clk);
    #1 rst = 1'b0;
    model_empty();
    boot_check("boot");
    sweep("boot");

    run_cmd("place_2_3", 1, 2, 3, 3, 0);
    run_cmd("place_oob_x_end", 1, 10, 0, 3, 0);
    run_cmd("place_collide", 1, 3, 1, 4, 1);
    run_cmd("shoot_hit", 2, 3, 3, 0, 0);
    run_cmd("shoot_miss", 2, 0, 0, 0, 0);
    run_cmd("shoot_repeat", 2, 3, 3, 0, 0);
    run_cmd("op_reserved", 3, 1, 1, 1, 0);
    run_cmd("place_len0", 1, 5, 5, 0, 0);
    run_cmd("place_len6", 1, 0, 0, 6, 1);
    run_cmd("place_x12", 1, 12, 0, 1, 0);
    run_cmd("place_wrap15", 1, 15, 0, 5, 0);
    run_cmd("place_edge_x11", 1, 11, 7, 1, 0);
    run_cmd("place_edge_y11", 1, 0, 7, 5, 1);
    run_cmd("place_y_end12", 1, 1, 8, 5, 1);
    run_cmd("shoot_y12", 2, 4, 12, 0, 0);
    run_cmd("place_6_6", 1, 6, 6, 5, 0);
    sweep("directed");

    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      op = (r < 6) ? 1 : (r < 9) ? 2 : 3;
      run_cmd($sformatf("rnd%0d_op%0d", i, op), op, int'($urandom_range(0, 13)),
              int'($urandom_range(0, 13)), int'($urandom_range(0, 6)), int'($urandom_range(0, 1)));
    end
    sweep("random");

    // CLEAR: each cycle read the address being overwritten; the display must show the old value
    for (int i = 0; i < 256; i++) old[i] = model[i];
    wait_ready(ok);
    chk("clear_ready", 32'(ok), 1);
    drive_cmd(0, 0, 0, 0, 0);
    disp_addr = 8'd0;
    early = 0;
    for (int n = 1; n <= 256; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("clear_readfirst_%0d", n - 1), 32'(disp_status), old[n - 1]);
      if (n < 256) begin
        if (done === 1'b1) early++;
        disp_addr = 8'(n);
      end
    end
    chk("clear_no_early_done", early, 0);
    chk("clear_done_257", 32'(done), 1);
    chk("clear_result", 32'(result), 0);
    @(posedge clk);
    #1;
    chk("clear_done_pulse", 32'(done), 0);
    model_empty();
    sweep("clear");

    // Reset in cycle 4 of a len-5 PLACE, with an earlier ship that must also be wiped
    run_cmd("place_pre_rst", 1, 7, 7, 2, 1);
    wait_ready(ok);
    chk("midrst_ready", 32'(ok), 1);
    drive_cmd(1, 0, 5, 5, 0);
    done_seen = 0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      @(posedge clk);
    end
    #1 rst = 1'b0;
    chk("midrst_no_done", done_seen, 0);
    model_empty();
    boot_check("midrst");
    sweep("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
